// File: rtl/core_ctrl_pkg.sv
// Shared types for the core run controller:
// state encoding and command opcodes.
package core_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_HALTED,
    S_STEP
  } state_t;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_RUN  = 2'b01;
  localparam logic [1:0] OP_HALT = 2'b10;
  localparam logic [1:0] OP_STEP = 2'b11;

endpackage

// File: rtl/core_run_ctrl_if.sv
// Host/debug command channel with a
// valid/ready handshake.
interface core_run_ctrl_if #(
  parameter int STEP_W = 16
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [STEP_W-1:0] cmd_steps;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_steps,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_steps,
    output cmd_ready
  );

endinterface

// File: rtl/core_step_cnt.sv
// Unsigned STEP down-counter; holds at zero
// so a zero load never wraps.
module core_step_cnt #(
  parameter int STEP_W = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              load,
  input  logic [STEP_W-1:0] load_val,
  input  logic              dec,
  output logic              last,
  output logic              zero
);

  logic [STEP_W-1:0] cnt;

  // load has priority over decrement
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);
  assign last = (cnt <= STEP_W'(1));

endmodule

// File: rtl/core_run_ctrl.sv
// Run controller for the core FSM: RUN/HALT/STEP.
// Macro CORE_RUN_CTRL_CYCLE_CNT_EN adds cycle_count.
module core_run_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int STEP_W = 16
) (
  input  logic                clk,
  input  logic                rstn,
  core_run_ctrl_if.slave      cmd,
  input  logic                ext_stall,
  input  logic                active,
  output logic                start,
  output logic                stall,
  output logic                halted,
  output logic                step_done,
  output logic [31:0]         cycle_count
);

  state_t            state;
  state_t            state_nx;
  logic              tgt_step;
  logic [STEP_W-1:0] steps_q;
  logic              arm;
  logic              arm_step;
  logic              cnt_load;
  logic [STEP_W-1:0] cnt_val;
  logic              cnt_dec;
  logic              cnt_last;
  logic              cnt_zero;
  logic              accept;

  assign cmd.cmd_ready = (state == S_IDLE)
                       | (state == S_RUN)
                       | (state == S_HALTED);
  assign accept  = cmd.cmd_valid & cmd.cmd_ready;
  assign start   = (state == S_LAUNCH);
  assign halted  = (state == S_HALTED);
  assign stall   = halted | ext_stall;
  assign cnt_dec = (state == S_STEP) & ~stall;

  core_step_cnt #(.STEP_W(STEP_W)) u_step_cnt (
    .clk      (clk),
    .rstn     (rstn),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .last     (cnt_last),
    .zero     (cnt_zero)
  );

  // next state, launch target capture, counter load
  always_comb begin
    state_nx = state;
    arm      = 1'b0;
    arm_step = 1'b0;
    cnt_load = 1'b0;
    cnt_val  = cmd.cmd_steps;
    case (state)
      S_IDLE: begin
        if (accept) begin
          unique case (cmd.cmd_op)
            OP_RUN: begin
              state_nx = S_LAUNCH;
              arm      = 1'b1;
            end
            OP_STEP: begin
              state_nx = S_LAUNCH;
              arm      = 1'b1;
              arm_step = 1'b1;
            end
            OP_HALT: state_nx = S_HALTED;
            OP_NOP:  ;
          endcase
        end
      end
      S_LAUNCH: begin
        if (!ext_stall) begin
          if (tgt_step) begin
            state_nx = S_STEP;
            cnt_load = 1'b1;
            cnt_val  = steps_q;
          end else begin
            state_nx = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (accept) begin
          unique case (cmd.cmd_op)
            OP_HALT: state_nx = S_HALTED;
            OP_STEP: begin
              state_nx = S_STEP;
              cnt_load = 1'b1;
            end
            OP_RUN, OP_NOP: ;
          endcase
        end
      end
      S_HALTED: begin
        if (accept) begin
          unique case (cmd.cmd_op)
            OP_RUN:  state_nx = S_RUN;
            OP_STEP: begin
              state_nx = S_STEP;
              cnt_load = 1'b1;
            end
            OP_HALT, OP_NOP: ;
          endcase
        end
      end
      S_STEP: begin
        if (cnt_zero || (cnt_last && !stall)) begin
          state_nx = S_HALTED;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // state register, launch target and step_done pulse
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      tgt_step  <= 1'b0;
      steps_q   <= '0;
      step_done <= 1'b0;
    end else begin
      state     <= state_nx;
      step_done <= (state == S_STEP)
                 & (state_nx == S_HALTED);
      if (arm) begin
        tgt_step <= arm_step;
        steps_q  <= cmd.cmd_steps;
      end
    end
  end

`ifdef CORE_RUN_CTRL_CYCLE_CNT_EN
  logic [31:0] cyc_q;

  // count cycles where the core really executes
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cyc_q <= '0;
    end else if (active && !stall) begin
      cyc_q <= cyc_q + 32'd1;
    end
  end

  assign cycle_count = cyc_q;
`else
  logic unused_active;
  assign unused_active = active;
  assign cycle_count   = '0;
`endif

endmodule

// File: tb/tb_core_run_ctrl.sv
// Bench for core_run_ctrl: directed timing
// scenarios plus random traffic vs a model.
module tb_core_run_ctrl;
  import core_ctrl_pkg::*;

  localparam int STEP_W = 16;

  localparam int P_IDLE   = 0;
  localparam int P_LAUNCH = 1;
  localparam int P_RUN    = 2;
  localparam int P_HALT   = 3;
  localparam int P_STEP   = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ext_stall;
  logic        active;
  logic        start;
  logic        stall;
  logic        halted;
  logic        step_done;
  logic [31:0] cycle_count;

  core_run_ctrl_if #(.STEP_W(STEP_W)) cmd_if ();

  core_run_ctrl #(.STEP_W(STEP_W)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .cmd         (cmd_if),
    .ext_stall   (ext_stall),
    .active      (active),
    .start       (start),
    .stall       (stall),
    .halted      (halted),
    .step_done   (step_done),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: operating mode, step budget,
  // executed-cycle total and a one-register core
  int        ph;
  int        tgt;
  int        latched;
  int        left;
  bit        m_done;
  bit [31:0] m_cnt;
  bit        core_act;

  logic        s_start, s_stall, s_halt;
  logic        s_done, s_rdy;
  logic [31:0] s_cnt;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ecnt(bit [31:0] v);
`ifdef CORE_RUN_CTRL_CYCLE_CNT_EN
    return v;
`else
    return (v == 32'hFFFF_FFFF) ? 32'd1 : 32'd0;
`endif
  endfunction

  // one clock: check outputs, advance the model
  task automatic tick();
    bit e_rdy, e_start, e_stall, e_halt, acc, nd;
    int np;
    int op;
    #1;
    e_rdy   = (ph != P_LAUNCH) && (ph != P_STEP);
    e_start = (ph == P_LAUNCH);
    e_halt  = (ph == P_HALT);
    e_stall = e_halt || ext_stall;
    chk("cmd_ready", cmd_if.cmd_ready, e_rdy);
    chk("start", start, e_start);
    chk("stall", stall, e_stall);
    chk("halted", halted, e_halt);
    chk("step_done", step_done, m_done);
    chk("cycle_count", cycle_count, ecnt(m_cnt));
    s_start = start;
    s_stall = stall;
    s_halt  = halted;
    s_done  = step_done;
    s_rdy   = cmd_if.cmd_ready;
    s_cnt   = cycle_count;
    acc = cmd_if.cmd_valid && e_rdy;
    op  = int'(cmd_if.cmd_op);
    nd  = 1'b0;
    np  = ph;
    case (ph)
      P_IDLE: if (acc) begin
        if (op == 1) begin
          np = P_LAUNCH; tgt = P_RUN;
        end else if (op == 3) begin
          np = P_LAUNCH; tgt = P_STEP;
          latched = int'(cmd_if.cmd_steps);
        end else if (op == 2) begin
          np = P_HALT;
        end
      end
      P_LAUNCH: if (!ext_stall) begin
        np = tgt; left = latched;
      end
      P_RUN: if (acc) begin
        if (op == 2) np = P_HALT;
        else if (op == 3) begin
          np = P_STEP; left = int'(cmd_if.cmd_steps);
        end
      end
      P_HALT: if (acc) begin
        if (op == 1) np = P_RUN;
        else if (op == 3) begin
          np = P_STEP; left = int'(cmd_if.cmd_steps);
        end
      end
      default: begin
        if (left == 0) begin
          np = P_HALT; nd = 1'b1;
        end else if (!e_stall) begin
          left--;
          if (left == 0) begin
            np = P_HALT; nd = 1'b1;
          end
        end
      end
    endcase
    @(posedge clk);
    if (active && !e_stall) m_cnt++;
    if (e_start && !e_stall) core_act = 1'b1;
    ph     = np;
    m_done = nd;
    #1;
    active = core_act;
  endtask

  // asynchronous reset with immediate output check
  task automatic do_reset();
    rstn = 1'b0;
    #1;
    chk("rst_start", start, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_step_done", step_done, 1'b0);
    chk("rst_cycle_count", cycle_count, 32'd0);
    chk("rst_cmd_ready", cmd_if.cmd_ready, 1'b1);
    chk("rst_stall", stall, ext_stall);
    ph = P_IDLE; tgt = P_RUN; latched = 0; left = 0;
    m_done = 1'b0; m_cnt = '0; core_act = 1'b0;
    active = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic send(logic [1:0] op, int n);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_steps = STEP_W'(n);
    tick();
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = OP_NOP;
  endtask

  initial begin
    int cnt_a, cnt_b, base;
    rstn = 1'b1;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = OP_NOP;
    cmd_if.cmd_steps = '0;
    ext_stall = 1'b0;
    active    = 1'b0;
    #2;
    do_reset();
    tick();

    // RUN from IDLE, no stall
    send(OP_RUN, 0);
    tick();
    chk("run_start_n1", s_start, 1'b1);
    chk("run_rdy_n1", s_rdy, 1'b0);
    tick();
    chk("run_start_n2", s_start, 1'b0);
    chk("run_cnt_n2", s_cnt, 32'd0);
    repeat (10) tick();
    chk("run_cnt_10", s_cnt, ecnt(10));

    // HALT, then STEP 5
    send(OP_HALT, 0);
    tick();
    chk("halt_stall_n1", s_stall, 1'b1);
    base = int'(s_cnt);
    send(OP_STEP, 5);
    cnt_a = 0; cnt_b = 0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (!s_stall) cnt_a++;
      if (s_done) cnt_b++;
      if (i == 6) chk("step5_done_n6", s_done, 1'b1);
    end
    chk("step5_unstalled", cnt_a, 5);
    chk("step5_done_pulses", cnt_b, 1);
    chk("step5_halted", s_halt, 1'b1);
    chk("step5_cnt_delta", s_cnt - 32'(base), ecnt(5));

    // STEP 4 with two ext_stall cycles inside
    base = int'(s_cnt);
    send(OP_STEP, 4);
    cnt_a = 0;
    for (int i = 1; i <= 8; i++) begin
      ext_stall = (i == 3) || (i == 4);
      tick();
      if (!s_halt) cnt_a++;
      if (i == 7) chk("step4_done_n7", s_done, 1'b1);
    end
    ext_stall = 1'b0;
    chk("step4_len", cnt_a, 6);
    chk("step4_cnt_delta", s_cnt - 32'(base), ecnt(4));

    // STEP 0 from HALTED
    send(OP_STEP, 0);
    tick();
    chk("step0_halt_n1", s_halt, 1'b0);
    tick();
    chk("step0_halt_n2", s_halt, 1'b1);
    chk("step0_done_n2", s_done, 1'b1);

    // RUN with ext_stall held in LAUNCH
    do_reset();
    tick();
    send(OP_RUN, 0);
    cnt_a = 0; cnt_b = 0;
    for (int i = 1; i <= 5; i++) begin
      ext_stall = (i <= 3);
      tick();
      if (s_start) cnt_a++;
      if (!s_rdy) cnt_b++;
    end
    ext_stall = 1'b0;
    chk("launch_start_len", cnt_a, 4);
    chk("launch_notready", cnt_b, 4);
    chk("launch_run_rdy", s_rdy, 1'b1);
    chk("launch_run_start", s_start, 1'b0);

    // reset in the middle of a long STEP
    send(OP_STEP, 50);
    repeat (4) tick();
    chk("midstep_rdy", s_rdy, 1'b0);
    ext_stall = 1'b1;
    do_reset();
    ext_stall = 1'b0;
    tick();
    chk("midstep_idle_rdy", s_rdy, 1'b1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cmd_if.cmd_valid = 1'($urandom_range(0, 1));
      cmd_if.cmd_op    = 2'($urandom_range(0, 3));
      cmd_if.cmd_steps = STEP_W'($urandom_range(0, 6));
      ext_stall        = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 149) == 0) do_reset();
      tick();
    end
    cmd_if.cmd_valid = 1'b0;
    ext_stall = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
